// File: rtl/sfifo_rd_stream_pkg.sv
// Shared constants for the sfifo read-side controllers.
//
// SFIFO_RD_LATENCY is the read latency of the sfifo when its output register
// is enabled. It is the cycle count from rden high to valid rdata, and it
// sets the depth of the skid queue in sfifo_rd_stream.
package sfifo_rd_stream_pkg;

  localparam int SFIFO_RD_LATENCY = 2;

endpackage

// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: converts the fixed-latency read port of an sfifo into a
// valid/ready stream.
//
// Reads are issued only when the output queue can absorb every read that
// could still return. count tracks queued entries plus reads in flight, so
// rden never depends on m_ready. The queue holds C_RD_LATENCY+2 entries,
// which is enough to sustain one beat per cycle with a consumer that is
// always ready.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst     in   synchronous, active-high reset
//   rdata   in   sfifo read data, valid C_RD_LATENCY cycles after rden
//   rempty  in   sfifo empty flag
//   rden    out  sfifo read enable
//   m_data  out  stream data, the head of the queue (don't-care when !m_valid)
//   m_valid out  stream beat valid
//   m_ready in   stream beat accepted
//
// Handshake: a beat transfers on each rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, it stays high and m_data
// stays stable until that transfer happens. m_valid never depends on
// m_ready.
module sfifo_rd_stream
  import sfifo_rd_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH = 0,
  parameter int C_RD_LATENCY = SFIFO_RD_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] rdata,
  input  logic                    rempty,
  output logic                    rden,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int DEPTH = C_RD_LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [C_DATA_WIDTH-1:0] queue [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;      // occupancy + reads in flight
  logic [CW-1:0]           occ;        // entries held in the queue
  logic [C_RD_LATENCY-1:0] in_flight;  // bit i: a read issued i+1 cycles ago
  logic                    capture;
  logic                    pop;

  // Pointers wrap explicitly, so DEPTH does not need to be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign rden    = !rst && !rempty && (count < DEPTH_C);
  assign capture = in_flight[C_RD_LATENCY-1];
  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != '0);
  assign m_data  = queue[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      occ       <= '0;
      in_flight <= '0;
    end else begin
      in_flight <= (in_flight << 1) | C_RD_LATENCY'(rden);

      if (capture) tail <= next_ptr(tail);
      if (pop)     head <= next_ptr(head);

      case ({rden, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({capture, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is left unreset. Only entries between head and tail are ever
  // presented on m_data.
  always_ff @(posedge clk) begin
    if (capture) queue[tail] <= rdata;
  end

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

  a_no_rden_empty: assert property (@(posedge clk) disable iff (rst)
    rempty |-> !rden);

  a_no_full_capture: assert property (@(posedge clk) disable iff (rst)
    capture |-> (occ < DEPTH_C));
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
module tb_sfifo_rd_stream;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rdata;
  logic       rempty;
  logic       rden;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;

  always #5 clk = ~clk;

  sfifo_rd_stream #(
    .C_DATA_WIDTH(8),
    .C_RD_LATENCY(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rdata  (rdata),
    .rempty (rempty),
    .rden   (rden),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  // ------------------------------------------------ behavioural sfifo, latency 2
  logic [7:0] mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] s1;

  assign rempty = (rd_ptr >= wr_ptr);

  always @(posedge clk) begin
    if (rden) begin
      s1     <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
    rdata <= s1;
  end

  // ----------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int         tests  = 0;
  int         fails  = 0;
  int         rden_n = 0;
  int         beats  = 0;
  int         max_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ----------------------------------------------------------------- drivers
  task automatic push_word(input logic [7:0] d, input bit expect_beat);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
    if (expect_beat) exp_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Samples the current cycle: counts rden, tracks count, scores handshakes.
  task automatic observe();
    logic [7:0] e;
    if (rden === 1'b1) rden_n++;
    if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("beat_extra", 32'(m_data), 32'h100);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(m_data), 32'(e));
      end
    end
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int first_valid;
    int last_beat;
    int stable_bad;

    // Reset with 16 words already waiting in the sfifo.
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rden", 32'(rden), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
    end
    rst     = 1'b0;
    m_ready = 1'b1;
    #1;
    check("rden_after_rst", 32'(rden), 32'd1);

    // Streaming: first beat 3 cycles after the first rden, then 16 back-to-back.
    first_valid = -1;
    last_beat   = -1;
    beats       = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (m_valid === 1'b1) last_beat = c;
      observe();
      step();
    end
    check("stream_latency", 32'(first_valid), 32'd3);
    check("stream_beats", 32'(beats), 32'd16);
    check("stream_span", 32'(last_beat - first_valid), 32'd15);

    // Backpressure: 8 words, consumer stalled.
    m_ready    = 1'b0;
    rden_n     = 0;
    stable_bad = 0;
    for (int i = 0; i < 8; i++) push_word(8'(i), 1'b0);
    #1;
    for (int c = 0; c < 12; c++) begin
      if (m_valid === 1'b1 && m_data !== 8'h00) stable_bad++;
      observe();
      step();
    end
    check("bp_rden_pulses", 32'(rden_n), 32'd4);
    check("bp_rden_idle", 32'(rden), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'h00);
    check("bp_stable", 32'(stable_bad), 32'd0);

    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    m_ready     = 1'b1;
    beats       = 0;
    first_valid = -1;
    last_beat   = -1;
    for (int c = 0; c < 30; c++) begin
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (m_valid === 1'b1) last_beat = c;
      observe();
      step();
    end
    check("bp_beats", 32'(beats), 32'd8);
    check("bp_first", 32'(first_valid), 32'd0);
    check("bp_span", 32'(last_beat - first_valid), 32'd7);

    // Empty sfifo: no reads, then a single word.
    rden_n = 0;
    for (int c = 0; c < 20; c++) begin
      observe();
      step();
    end
    check("empty_no_rden", 32'(rden_n), 32'd0);

    push_word(8'hA5, 1'b1);
    #1;
    check("single_rden", 32'(rden), 32'd1);
    beats       = 0;
    first_valid = -1;
    for (int c = 0; c < 10; c++) begin
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      observe();
      step();
    end
    check("single_latency", 32'(first_valid), 32'd3);
    check("single_beats", 32'(beats), 32'd1);

    // Toggling consumer over 32 words.
    beats   = 0;
    max_cnt = 0;
    for (int i = 0; i < 32; i++) push_word(8'h20 + 8'(i), 1'b1);
    #1;
    for (int c = 0; c < 300 && beats < 32; c++) begin
      m_ready = (c % 2 == 0);
      observe();
      step();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      observe();
      step();
    end
    check("toggle_beats", 32'(beats), 32'd32);
    check("toggle_drained", 32'(exp_q.size()), 32'd0);
    check("toggle_count_max", 32'(max_cnt <= 4), 32'd1);

    // Reset mid-stream with 2 reads in flight and 2 entries queued.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i), 1'b0);
    #1;
    for (int c = 0; c < 4; c++) begin
      observe();
      step();
    end
    check("mid_pre_valid", 32'(m_valid), 32'd1);
    check("mid_pre_count", 32'(dut.count), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_rden", 32'(rden), 32'd1);
    for (int i = 4; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
    m_ready = 1'b1;
    beats   = 0;
    for (int c = 0; c < 30; c++) begin
      observe();
      step();
    end
    check("mid_beats", 32'(beats), 32'd4);
    check("mid_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sfifo_rd_stream.md
SFIFO_RD_STREAM -- requirements
Module: sfifo_rd_stream

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 0 (must be overridden), giving the data width in bits.
REQ-002 SHALL have parameter C_RD_LATENCY, default 2, giving the cycles from rden high to valid rdata of the upstream sfifo.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rdata  input  C_DATA_WIDTH  sfifo read data, valid C_RD_LATENCY cycles after rden.
REQ-006 SHALL have port rempty  input  1  sfifo empty flag.
REQ-007 SHALL have port rden  output  1  sfifo read enable.
REQ-008 SHALL have port m_data  output  C_DATA_WIDTH  stream data.
REQ-009 SHALL have port m_valid  output  1  stream beat valid.
REQ-010 SHALL have port m_ready  input  1  stream beat accepted by the consumer.

Function
REQ-011 SHALL define internal constant DEPTH = C_RD_LATENCY+2, the output-queue depth.
REQ-012 SHALL keep registered count = queue occupancy + reads in flight, width $clog2(DEPTH+1).
REQ-013 SHALL drive rden = !rempty && (count < DEPTH), with no combinational path from m_ready to rden.
REQ-014 SHALL track reads in flight with a C_RD_LATENCY-stage valid shift register, shifting in rden each cycle.
REQ-015 SHALL write rdata into the queue at the tail pointer on the cycle the shift-register output is 1, i.e. C_RD_LATENCY cycles after the rden cycle.
REQ-016 SHALL assert m_valid the cycle after capture; worst-case rden to m_valid latency is C_RD_LATENCY+1 cycles.
REQ-017 SHALL drive m_data = queue[head] combinationally from registers; m_data is don't-care while m_valid=0.
REQ-018 SHALL pop one entry (head advance, count-1) on each clk with m_valid && m_ready.
REQ-019 SHALL hold m_data stable while m_valid && !m_ready, per valid/ready rules.
REQ-020 SHALL never deassert m_valid without a handshake.
REQ-021 SHALL update count by +rden -pop in the same cycle; simultaneous rden and pop leaves count unchanged.
REQ-022 SHALL also allow a simultaneous capture and pop; occupancy is then unchanged and the pointers both advance.
REQ-023 SHALL wrap head and tail pointers modulo DEPTH, including non-power-of-two DEPTH.
REQ-024 SHALL sustain one beat per cycle indefinitely when rempty=0 and m_ready=1.
REQ-025 SHALL never assert rden while rempty=1, so the sfifo RDERR is never set.
REQ-026 SHALL never capture into a full queue; this is guaranteed by REQ-013 and checked by an assertion.
REQ-027 SHALL deliver beats strictly in sfifo order, with no loss or duplication.

Reset
REQ-028 SHALL, while rst=1, force rden=0, m_valid=0, count=0, head=tail=0 and the in-flight shift register to all zeros.
REQ-029 SHALL leave queue storage unreset (don't-care).
REQ-030 SHALL discard in-flight reads on reset mid-operation: no pre-reset data appears after rst falls.
REQ-031 SHALL permit the earliest rden on the first cycle after rst falls.

Structure
REQ-032 SHALL place the C_RD_LATENCY default (2, matching the sfifo output-register configuration) in the shared controller package as a named constant.
REQ-033 SHALL need no new typedefs.
REQ-034 SHALL be flat: queue, pointers, count and shift register all inline, with no sub-module.
REQ-035 SHALL carry concurrent assertions, excluded from synthesis, for REQ-019, REQ-025 and REQ-026.

Verification
Benches use C_DATA_WIDTH=8 and C_RD_LATENCY=2 (DEPTH=4), with a behavioural sfifo model of latency 2.
REQ-036 SHALL cover reset: rst=1 for 3 cycles with the model holding data -> rden=0 and m_valid=0 throughout; rden=1 on the first cycle after rst falls.
REQ-037 SHALL cover streaming: 16 words 0x00..0x0F preloaded, m_ready=1 -> first m_valid 3 cycles after the first rden, then 16 consecutive beats 0x00..0x0F, one per cycle.
REQ-038 SHALL cover backpressure: 8 words preloaded, m_ready=0 -> exactly 4 rden pulses, then rden=0 and m_data=0x00 stable; m_ready=1 -> 0x00..0x07 in order, back-to-back.
REQ-039 SHALL cover the empty FIFO: rempty=1 for 20 cycles -> rden never 1; one write of 0xA5 -> single beat 0xA5 within 3 cycles of rden.
REQ-040 SHALL cover a toggling consumer: m_ready pattern 1,0,1,0,... over 32 words -> all 32 delivered in order, with no duplicate and count never above 4.
REQ-041 SHALL cover reset mid-stream: rst pulsed for 1 cycle with 2 reads in flight and 2 queued -> m_valid=0 the next cycle, and the first post-reset beat is the next word the model returns after reset.
